uart_frame_ctrl: RTL and testbench

UART_FRAME_CTRL -- requirements
Module: uart_frame_ctrl

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_frame_ctrl_if.sv | 34 +++
 rtl/uart_frame_buf.sv | 28 ++
 rtl/uart_frame_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_uart_frame_ctrl.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame controller: FSM encoding and the
// default frame start marker.
package uart_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_GET_LEN     = 3'd1,
    ST_GET_PAYLOAD = 3'd2,
    ST_GET_CHK     = 3'd3,
    ST_DRAIN       = 3'd4
  } state_t;

  // States in which the frame is still being collected and the inter-byte
  // timeout is armed.
  function automatic logic is_collect(state_t s);
    return (s == ST_GET_LEN) || (s == ST_GET_PAYLOAD) || (s == ST_GET_CHK);
  endfunction

endpackage

// File: rtl/uart_frame_ctrl_if.sv
// Byte input and payload stream output of the UART frame controller.
interface uart_frame_ctrl_if #(
  parameter int DATA_BITS = 8,
  parameter int MAX_LEN   = 16
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic                 byte_valid;
  logic [DATA_BITS-1:0] byte_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_BITS-1:0] out_data;
  logic                 out_last;
  logic [LEN_W-1:0]     frame_len;
  logic                 err_len;
  logic                 err_chk;
  logic                 err_timeout;
  logic                 err_overrun;

  // Byte source and payload consumer side.
  modport master (
    output byte_valid, byte_data, out_ready,
    input  out_valid, out_data, out_last, frame_len,
    input  err_len, err_chk, err_timeout, err_overrun
  );

  // Frame controller side.
  modport slave (
    input  byte_valid, byte_data, out_ready,
    output out_valid, out_data, out_last, frame_len,
    output err_len, err_chk, err_timeout, err_overrun
  );

endinterface

// File: rtl/uart_frame_buf.sv
// Payload register file: one synchronous write port, one asynchronous read
// port. Contents are never cleared; the controller only reads entries that
// were written by the frame currently being drained.
module uart_frame_buf #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [DATA_BITS-1:0] rd_data
);

  logic [DATA_BITS-1:0] mem [DEPTH];

  // Store one payload byte per write strobe.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_frame_ctrl.sv
// UART frame controller: parses SYNC, LEN, payload, CHK frames from a byte
// stream, buffers the payload and drains it over a valid/ready stream.
module uart_frame_ctrl
  import uart_pkg::*;
#(
  parameter int                   DATA_BITS    = 8,
  parameter int                   MAX_LEN      = 16,
  parameter int                   TIMEOUT_CLKS = 2170,
  parameter logic [DATA_BITS-1:0] SYNC_BYTE    = DATA_BITS'(SYNC_BYTE_DEFAULT)
) (
  input  logic             clk,
  input  logic             reset_n,
  uart_frame_ctrl_if.slave bus
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int PTR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMO_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

  state_t               state_reg, state_next;
  logic [LEN_W-1:0]     len_reg;
  logic [DATA_BITS-1:0] chk_reg;
  logic [PTR_W-1:0]     wr_ptr_reg;
  logic [PTR_W-1:0]     rd_ptr_reg;
  logic [TMO_W-1:0]     tmo_cnt_reg;
  logic                 err_len_reg, err_chk_reg, err_timeout_reg, err_overrun_reg;

  logic                 in_collect;
  logic                 len_ok;
  logic                 chk_ok;
  logic                 last_payload;
  logic                 last_read;
  logic                 tmo_hit;
  logic                 out_valid_int;
  logic                 handshake;
  logic                 buf_we;
  logic                 err_len_next, err_chk_next, err_timeout_next, err_overrun_next;
  logic [DATA_BITS-1:0] rd_data;

  // Frame-field decode shared by the FSM and the datapath.
  assign in_collect   = is_collect(state_reg);
  assign len_ok       = (bus.byte_data != '0) && (bus.byte_data <= DATA_BITS'(MAX_LEN));
  assign chk_ok       = (bus.byte_data == chk_reg);
  assign last_payload = (LEN_W'(wr_ptr_reg) == (len_reg - LEN_W'(1)));
  assign last_read    = (LEN_W'(rd_ptr_reg) == (len_reg - LEN_W'(1)));
  // A byte arriving on the expiry cycle wins over the timeout.
  assign tmo_hit      = in_collect && !bus.byte_valid &&
                        (tmo_cnt_reg == TMO_W'(TIMEOUT_CLKS - 1));

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.byte_valid && (bus.byte_data == SYNC_BYTE)) begin
          state_next = ST_GET_LEN;
        end
      end
      ST_GET_LEN: begin
        if (bus.byte_valid) begin
          state_next = len_ok ? ST_GET_PAYLOAD : ST_IDLE;
        end else if (tmo_hit) begin
          state_next = ST_IDLE;
        end
      end
      ST_GET_PAYLOAD: begin
        if (bus.byte_valid) begin
          if (last_payload) begin
            state_next = ST_GET_CHK;
          end
        end else if (tmo_hit) begin
          state_next = ST_IDLE;
        end
      end
      ST_GET_CHK: begin
        if (bus.byte_valid) begin
          state_next = chk_ok ? ST_DRAIN : ST_IDLE;
        end else if (tmo_hit) begin
          state_next = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (handshake && last_read) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: stream valid, buffer write strobe and error pulse requests.
  always_comb begin
    out_valid_int    = 1'b0;
    buf_we           = 1'b0;
    err_len_next     = 1'b0;
    err_chk_next     = 1'b0;
    err_timeout_next = tmo_hit;
    err_overrun_next = 1'b0;
    case (state_reg)
      ST_GET_LEN:     err_len_next     = bus.byte_valid && !len_ok;
      ST_GET_PAYLOAD: buf_we           = bus.byte_valid;
      ST_GET_CHK:     err_chk_next     = bus.byte_valid && !chk_ok;
      ST_DRAIN: begin
        out_valid_int    = 1'b1;
        err_overrun_next = bus.byte_valid;
      end
      default: ;
    endcase
  end

  assign handshake = out_valid_int && bus.out_ready;

  // Frame datapath: length, running checksum, pointers, timeout, error pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_reg         <= '0;
      chk_reg         <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      tmo_cnt_reg     <= '0;
      err_len_reg     <= 1'b0;
      err_chk_reg     <= 1'b0;
      err_timeout_reg <= 1'b0;
      err_overrun_reg <= 1'b0;
    end else begin
      err_len_reg     <= err_len_next;
      err_chk_reg     <= err_chk_next;
      err_timeout_reg <= err_timeout_next;
      err_overrun_reg <= err_overrun_next;

      if (bus.byte_valid || !in_collect || tmo_hit) begin
        tmo_cnt_reg <= '0;
      end else begin
        tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
      end

      if ((state_reg == ST_GET_LEN) && bus.byte_valid && len_ok) begin
        len_reg <= LEN_W'(bus.byte_data);
        chk_reg <= bus.byte_data;
      end else if (buf_we) begin
        chk_reg <= chk_reg ^ bus.byte_data;
      end

      // Pointers return to zero at the end of each pass so they never wrap.
      if (state_reg == ST_IDLE) begin
        wr_ptr_reg <= '0;
      end else if (buf_we) begin
        wr_ptr_reg <= last_payload ? '0 : wr_ptr_reg + PTR_W'(1);
      end

      if (state_reg == ST_IDLE) begin
        rd_ptr_reg <= '0;
      end else if (handshake) begin
        rd_ptr_reg <= last_read ? '0 : rd_ptr_reg + PTR_W'(1);
      end
    end
  end

  uart_frame_buf #(
    .DATA_BITS (DATA_BITS),
    .DEPTH     (MAX_LEN),
    .ADDR_W    (PTR_W)
  ) u_buf (
    .clk     (clk),
    .wr_en   (buf_we),
    .wr_addr (wr_ptr_reg),
    .wr_data (bus.byte_data),
    .rd_addr (rd_ptr_reg),
    .rd_data (rd_data)
  );

  // Outputs are gated by out_valid so reset and idle drive them low.
  assign bus.out_valid   = out_valid_int;
  assign bus.out_data    = out_valid_int ? rd_data : '0;
  assign bus.out_last    = out_valid_int && last_read;
  assign bus.frame_len   = out_valid_int ? len_reg : '0;
  assign bus.err_len     = err_len_reg;
  assign bus.err_chk     = err_chk_reg;
  assign bus.err_timeout = err_timeout_reg;
  assign bus.err_overrun = err_overrun_reg;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Bench for uart_frame_ctrl: table of directed frames, hand-written corner
// sequences and randomized frames checked against a frame-level model.
module tb_uart_frame_ctrl;

  localparam int DATA_BITS = 8;
  localparam int MAX_LEN   = 16;
  localparam int TMO       = 40;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  uart_frame_ctrl_if #(.DATA_BITS(DATA_BITS), .MAX_LEN(MAX_LEN)) bus ();

  uart_frame_ctrl #(
    .DATA_BITS    (DATA_BITS),
    .MAX_LEN      (MAX_LEN),
    .TIMEOUT_CLKS (TMO),
    .SYNC_BYTE    (8'hA5)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;
  int c_len, c_chk, c_tmo, c_ovr;
  logic [7:0] got_q [$];
  int         got_len_q [$];
  int         got_last_q [$];
  logic [7:0] exp_q [$];
  bit rand_ready = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    bus.byte_valid = 1'b1;
    bus.byte_data  = d;
    @(posedge clk); #1;
    bus.byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_counts();
    c_len = 0; c_chk = 0; c_tmo = 0; c_ovr = 0;
    got_q.delete(); got_len_q.delete(); got_last_q.delete();
  endtask

  // Waits (bounded) for exp_q.size() payload bytes, then compares everything.
  task automatic check_frame(input string name, input int e_len, input int e_chk,
                             input int e_tmo, input int e_ovr);
    for (int k = 0; k < 600 && got_q.size() < exp_q.size(); k++) idle(1);
    idle(3);
    check({name, ".count"}, got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      check($sformatf("%s.data[%0d]", name, k), got_q[k], exp_q[k]);
      check($sformatf("%s.len[%0d]", name, k), got_len_q[k], exp_q.size());
      check($sformatf("%s.last[%0d]", name, k), got_last_q[k], int'(k == exp_q.size() - 1));
    end
    check({name, ".err_len"}, c_len, e_len);
    check({name, ".err_chk"}, c_chk, e_chk);
    check({name, ".err_timeout"}, c_tmo, e_tmo);
    check({name, ".err_overrun"}, c_ovr, e_ovr);
    $display("frame %s: %0d bytes, errs len=%0d chk=%0d tmo=%0d ovr=%0d",
             name, got_q.size(), c_len, c_chk, c_tmo, c_ovr);
  endtask

  // Output monitor: error exclusivity, stream stability and capture.
  initial begin
    logic prev_hs, prev_last, prev_stall;
    logic [7:0] prev_data;
    int sum;
    prev_hs = 0; prev_last = 0; prev_stall = 0; prev_data = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_hs = 0; prev_stall = 0;
      end else begin
        sum = int'(bus.err_len) + int'(bus.err_chk) + int'(bus.err_timeout) + int'(bus.err_overrun);
        check("err_onehot", int'(sum > 1), 0);
        if (bus.err_len)     c_len++;
        if (bus.err_chk)     c_chk++;
        if (bus.err_timeout) c_tmo++;
        if (bus.err_overrun) c_ovr++;
        if (!bus.out_valid) check("frame_len_idle", bus.frame_len, 0);
        if (prev_hs && !prev_last) check("valid_continues", bus.out_valid, 1);
        if (prev_hs && prev_last)  check("valid_drops_after_last", bus.out_valid, 0);
        if (prev_stall) begin
          check("stall_valid", bus.out_valid, 1);
          check("stall_data", bus.out_data, prev_data);
          check("stall_last", bus.out_last, prev_last);
        end
        if (bus.out_valid && bus.out_ready) begin
          got_q.push_back(bus.out_data);
          got_len_q.push_back(int'(bus.frame_len));
          got_last_q.push_back(int'(bus.out_last));
        end
        prev_hs    = bus.out_valid && bus.out_ready;
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_last  = bus.out_last;
        prev_data  = bus.out_data;
      end
    end
  end

  // Random backpressure during the randomized phase.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  typedef struct {
    string        name;
    logic [159:0] seq;    // right-aligned, first byte most significant
    int           n;
    int           off;
    int           n_out;
    int           e_len;
    int           e_chk;
  } vec_t;

  localparam int NV = 7;
  vec_t vt [NV];

  initial begin
    logic [7:0] b;
    vt[0] = '{name:"good3",   seq:160'hA50311223303, n:6, off:2, n_out:3, e_len:0, e_chk:0};
    vt[1] = '{name:"badchk",  seq:160'hA502AABB00, n:5, off:2, n_out:0, e_len:0, e_chk:1};
    vt[2] = '{name:"len0",    seq:160'h007FA500, n:4, off:0, n_out:0, e_len:1, e_chk:0};
    vt[3] = '{name:"len17",   seq:160'hA511, n:2, off:0, n_out:0, e_len:1, e_chk:0};
    vt[4] = '{name:"len16",   seq:160'hA510000102030405060708090A0B0C0D0E0F10,
              n:19, off:2, n_out:16, e_len:0, e_chk:0};
    vt[5] = '{name:"noise1",  seq:160'h12A5015C5D, n:5, off:3, n_out:1, e_len:0, e_chk:0};
    vt[6] = '{name:"syncdat", seq:160'hA502A5A502, n:5, off:2, n_out:2, e_len:0, e_chk:0};

    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;
    bus.out_ready  = 1'b1;
    clear_counts();

    // Reset state.
    #1;
    check("rst.out_valid", bus.out_valid, 0);
    check("rst.out_data", bus.out_data, 0);
    check("rst.frame_len", bus.frame_len, 0);
    check("rst.errs", int'({bus.err_len, bus.err_chk, bus.err_timeout, bus.err_overrun}), 0);
    idle(3);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Table-driven frames.
    for (int i = 0; i < NV; i++) begin
      clear_counts();
      for (int k = 0; k < vt[i].n; k++) send_byte(vt[i].seq[8*(vt[i].n-1-k) +: 8]);
      exp_q.delete();
      for (int k = 0; k < vt[i].n_out; k++)
        exp_q.push_back(vt[i].seq[8*(vt[i].n-1-(vt[i].off+k)) +: 8]);
      check_frame(vt[i].name, vt[i].e_len, vt[i].e_chk, 0, 0);
    end

    // Timeout fires exactly once, TIMEOUT_CLKS idle cycles after the last byte.
    clear_counts();
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01);
    idle(TMO - 1);
    check("tmo.early", c_tmo, 0);
    idle(2);
    check("tmo.fire", c_tmo, 1);
    idle(3 * TMO);
    check("tmo.once", c_tmo, 1);
    exp_q.delete();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'hFF); send_byte(8'hFE);
    exp_q.push_back(8'hFF);
    check_frame("tmo.after", 0, 0, 1, 0);

    // Byte on the expiry cycle is taken.
    clear_counts();
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01);
    idle(TMO - 1);
    send_byte(8'h02); send_byte(8'h03); send_byte(8'h04); send_byte(8'h00);
    exp_q.delete();
    exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    exp_q.push_back(8'h03); exp_q.push_back(8'h04);
    check_frame("tmo.expiry_byte", 0, 0, 0, 0);

    // Overrun during a stalled drain, then intact payload.
    clear_counts();
    bus.out_ready = 1'b0;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'hC1); send_byte(8'hC2); send_byte(8'h01);
    idle(3);
    send_byte(8'hA5); idle(1); send_byte(8'h7E);
    idle(3);
    check("ovr.count", c_ovr, 2);
    check("ovr.held", bus.out_valid, 1);
    check("ovr.nodata", got_q.size(), 0);
    bus.out_ready = 1'b1;
    exp_q.delete();
    exp_q.push_back(8'hC1); exp_q.push_back(8'hC2);
    check_frame("ovr.drain", 0, 0, 0, 2);

    // Reset mid-drain.
    clear_counts();
    bus.out_ready = 1'b0;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h44); send_byte(8'h55);
    send_byte(8'h66); send_byte(8'h74);
    for (int k = 0; k < 20 && !bus.out_valid; k++) idle(1);
    check("rstdrain.valid_before", bus.out_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    check("rstdrain.valid_async", bus.out_valid, 0);
    check("rstdrain.data_async", bus.out_data, 0);
    check("rstdrain.len_async", bus.frame_len, 0);
    idle(3);
    @(posedge clk); #1;
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h9A); send_byte(8'hBC); send_byte(8'h24);
    exp_q.delete();
    exp_q.push_back(8'h9A); exp_q.push_back(8'hBC);
    check_frame("rstdrain.next", 0, 0, 0, 0);

    // Randomized frames against the frame-level model.
    rand_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int kind, len, nnoise, e_len, e_chk;
      logic [7:0] pay [$];
      logic [7:0] chk, sent_chk;
      clear_counts();
      exp_q.delete();
      kind = $urandom_range(0, 9);
      nnoise = $urandom_range(0, 2);
      for (int k = 0; k < nnoise; k++) begin
        do b = 8'($urandom); while (b == 8'hA5);
        send_byte(b);
        idle($urandom_range(0, 2));
      end
      if (kind == 9) len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAX_LEN + 1, 255);
      else len = $urandom_range(1, MAX_LEN);
      send_byte(8'hA5);
      idle(($urandom_range(0, 15) == 0) ? TMO - 1 : $urandom_range(0, 2));
      send_byte(8'(len));
      e_len = 0; e_chk = 0;
      if (len < 1 || len > MAX_LEN) begin
        e_len = 1;
      end else begin
        pay.delete();
        chk = 8'(len);
        for (int k = 0; k < len; k++) begin
          b = 8'($urandom);
          pay.push_back(b);
          chk ^= b;
          idle(($urandom_range(0, 15) == 0) ? TMO - 1 : $urandom_range(0, 2));
          send_byte(b);
        end
        sent_chk = (kind == 8) ? (chk ^ 8'(1 << $urandom_range(0, 7))) : chk;
        idle(($urandom_range(0, 15) == 0) ? TMO - 1 : $urandom_range(0, 2));
        send_byte(sent_chk);
        if (sent_chk != chk) e_chk = 1;
        else foreach (pay[k]) exp_q.push_back(pay[k]);
      end
      check_frame($sformatf("rand%0d", f), e_len, e_chk, 0, 0);
    end
    rand_ready = 1'b0;
    bus.out_ready = 1'b1;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
